inst_fetch: RTL and testbench

Front-end instruction fetch stage that feeds the RV64I decoder. Holds the architectural fetch PC, issues in-order 32-bit instruction reads to the instruction memory port, and buffers returned words with their PCs in a small FIFO. It presents `{pc, inst}` pairs to decode over a valid/ready handshake. It handles redirects from the branch unit, including in-flight responses that become stale after a redirect.

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/inst_fifo.sv | 66 ++++++
 rtl/inst_fetch.sv | 120 ++++++++++++
 tb/tb_inst_fetch.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared core constants and the fetch-to-decode entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP          = 64'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : inst_fifo
// Description : Synchronous FIFO of fetch entries; flush beats push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_cnt_w-1:0] count_q;
    logic               w_push;
    logic               w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == c_cnt_w'(DEPTH));
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_ptr_w'(1);
            end
            count_q <= count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    // Storage carries no reset; entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (w_push && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Credit-based instruction fetch stage with redirect handling.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              IBUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            inst_req_valid,
    input  logic            inst_req_ready,
    output logic [XLEN-1:0] inst_req_addr,
    input  logic            inst_resp_valid,
    input  logic [ILEN-1:0] inst_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst
);

    localparam int c_cnt_w = $clog2(IBUF_DEPTH) + 1;

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    resp_pc_q, resp_pc_d;
    logic [c_cnt_w-1:0] outstanding_q, outstanding_d;
    logic [c_cnt_w-1:0] stale_q, stale_d;

    logic [c_cnt_w-1:0] w_fifo_count;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_credit;
    logic               w_req_fire;
    logic               w_resp_stale;
    logic               w_push;
    logic               w_pop;
    logic [XLEN-1:0]    w_redirect_pc;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;

    assign w_redirect_pc = redirect_pc & ~(XLEN'(3));

    // Buffer slots plus in-flight requests never exceed the depth, so every
    // response has a home when it arrives.
    assign w_credit = !w_fifo_full &&
                      (({1'b0, w_fifo_count} + {1'b0, outstanding_q}) < (c_cnt_w+1)'(IBUF_DEPTH));

    assign inst_req_valid = !rst && !redirect_valid && w_credit;
    assign inst_req_addr  = fetch_pc_q;
    assign w_req_fire     = inst_req_valid && inst_req_ready;

    assign w_resp_stale = (stale_q != '0);
    assign w_push       = inst_resp_valid && !w_resp_stale && !redirect_valid;
    assign w_push_entry = '{pc: resp_pc_q, inst: inst_resp_data};

    assign out_valid = !w_fifo_empty && !redirect_valid;
    assign w_pop     = out_valid && out_ready;
    assign out_pc    = w_fifo_empty ? '0 : w_head.pc;
    assign out_inst  = w_fifo_empty ? '0 : w_head.inst;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        stale_d       = stale_q;
        outstanding_d = outstanding_q + c_cnt_w'(w_req_fire) - c_cnt_w'(inst_resp_valid);
        if (w_req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        if (w_push) begin
            resp_pc_d = resp_pc_q + PC_STEP;
        end
        if (inst_resp_valid && w_resp_stale) begin
            stale_d = stale_q - c_cnt_w'(1);
        end
        // A response landing in the redirect cycle is dropped outright.
        if (redirect_valid) begin
            fetch_pc_d = w_redirect_pc;
            resp_pc_d  = w_redirect_pc;
            stale_d    = outstanding_q - c_cnt_w'(inst_resp_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    inst_fifo #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (redirect_valid),
        .head_o      (w_head),
        .count_o     (w_fifo_count),
        .empty_o     (w_fifo_empty),
        .full_o      (w_fifo_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Directed bench with a memory model and an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int          c_depth    = 4;
    localparam logic [63:0] c_reset_pc = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req_valid;
    logic        inst_req_ready = 1'b0;
    logic [63:0] inst_req_addr;
    logic        inst_resp_valid = 1'b0;
    logic [31:0] inst_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    inst_fetch #(
        .RESET_PC   (c_reset_pc),
        .IBUF_DEPTH (c_depth)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_req_valid  (inst_req_valid),
        .inst_req_ready  (inst_req_ready),
        .inst_req_addr   (inst_req_addr),
        .inst_resp_valid (inst_resp_valid),
        .inst_resp_data  (inst_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
        int          epoch;
    } mem_req_t;

    mem_req_t     mq[$];
    fetch_entry_t sb[$];
    int           tests   = 0;
    int           fails   = 0;
    int           cyc     = 0;
    int           epoch   = 0;
    int           mem_lat = 1;
    logic [63:0]  exp_addr = c_reset_pc;
    logic         s_req_valid, s_req_fire, s_out_valid, s_out_fire;
    logic [63:0]  s_req_addr, s_out_pc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample/compare, then advance the memory and scoreboard model.
    task automatic cycle();
        fetch_entry_t e;
        mem_req_t     m;
        #1;
        s_req_valid = inst_req_valid;
        s_req_addr  = inst_req_addr;
        s_req_fire  = inst_req_valid && inst_req_ready;
        s_out_valid = out_valid;
        s_out_fire  = out_valid && out_ready;
        s_out_pc    = out_pc;
        if (!rst) begin
            if (inst_req_valid) chk("req_addr", inst_req_addr, exp_addr);
            if (redirect_valid) begin
                chk("redir_req_valid", {63'd0, inst_req_valid}, 64'd0);
                chk("redir_out_valid", {63'd0, out_valid}, 64'd0);
            end
            if (s_out_fire) begin
                tests++;
                assert (sb.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_out observed=pc %h expected=no entry", out_pc);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", {32'd0, out_inst}, {32'd0, e.inst});
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            sb.delete();
            exp_addr = c_reset_pc;
        end else begin
            if (inst_resp_valid) begin
                m = mq.pop_front();
                if (!redirect_valid && m.epoch == epoch)
                    sb.push_back('{pc: m.addr, inst: mem_word(m.addr)});
            end
            if (redirect_valid) begin
                sb.delete();
                epoch++;
                exp_addr = redirect_pc & ~64'h3;
            end
            if (s_req_fire) begin
                mq.push_back('{addr: s_req_addr, due: cyc + mem_lat, epoch: epoch});
                exp_addr = exp_addr + 64'd4;
            end
        end
        cyc++;
        #1;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            inst_resp_valid = 1'b1;
            inst_resp_data  = mem_word(mq[0].addr);
        end else begin
            inst_resp_valid = 1'b0;
            inst_resp_data  = '0;
        end
    endtask

    task automatic wait_out(input string tag, input logic [63:0] exp_pc, output int lat);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (s_out_fire) begin
                lat = i + 1;
                break;
            end
        end
        tests++;
        assert (lat > 0) else begin
            fails++;
            $error("FAIL %s_timeout observed=no output expected=output", tag);
        end
        if (lat > 0) chk(tag, s_out_pc, exp_pc);
    endtask

    initial begin
        int c0, c1, n, lat;
        bit found;

        // Reset state
        rst = 1'b1; out_ready = 1'b1; inst_req_ready = 1'b1; mem_lat = 1;
        repeat (3) cycle();
        chk("rst_req_valid", {63'd0, inst_req_valid}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_req_addr", inst_req_addr, c_reset_pc);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_inst", {32'd0, out_inst}, 64'd0);

        // Reset release, 1-cycle memory, streaming
        rst = 1'b0; c0 = -1; c1 = -1; n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_req_fire && c0 < 0) c0 = i;
            if (s_out_fire && c1 < 0) c1 = i;
            if (i >= 4 && s_out_fire) n++;
        end
        chk("t1_first_req_cycle", 64'(c0), 64'd0);
        chk("t1_out_latency", 64'(c1 - c0), 64'd2);
        chk("t1_throughput", 64'(n), 64'd8);

        // Back-pressure
        rst = 1'b1; out_ready = 1'b0;
        repeat (2) cycle();
        rst = 1'b0; n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_req_fire) n++;
        end
        chk("t2_reqs_when_full", 64'(n), 64'd4);
        chk("t2_req_valid_low", {63'd0, s_req_valid}, 64'd0);
        out_ready = 1'b1;
        cycle();
        chk("t2_pop", {63'd0, s_out_fire}, 64'd1);
        chk("t2_no_same_cycle_credit", {63'd0, s_req_valid}, 64'd0);
        out_ready = 1'b0;
        cycle();
        chk("t2_credit_next_cycle", {63'd0, s_req_fire}, 64'd1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (s_req_fire) n++;
        end
        chk("t2_no_extra_reqs", 64'(n), 64'd0);

        // Redirect with 3 outstanding on 3-cycle memory
        rst = 1'b1; out_ready = 1'b1; mem_lat = 3;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (3) cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0102;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("t3_req_valid", {63'd0, s_req_valid}, 64'd1);
        chk("t3_req_addr", s_req_addr, 64'h0000_0000_8000_0100);
        wait_out("t3_first_out_pc", 64'h0000_0000_8000_0100, lat);

        // Redirect coinciding with a response and a pop
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (out_valid && inst_resp_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_setup_found", {63'd0, found}, 64'd1);
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_0000_4000;
        cycle();
        chk("t4_out_valid_redirect", {63'd0, s_out_valid}, 64'd0);
        redirect_valid = 1'b0;
        wait_out("t4_first_out_pc", 64'h0000_0000_0000_4000, lat);
        chk("t4_latency", 64'(lat), 64'd5);

        // Back-to-back redirects
        repeat (3) cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        cycle();
        redirect_pc = 64'h200;
        cycle();
        redirect_valid = 1'b0;
        wait_out("t5_first_out_pc", 64'h200, lat);
        repeat (6) cycle();

        // PC wrap-around
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("t6_req0_valid", {63'd0, s_req_fire}, 64'd1);
        chk("t6_req0_addr", s_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle();
        chk("t6_req1_valid", {63'd0, s_req_fire}, 64'd1);
        chk("t6_req1_addr", s_req_addr, 64'h0);
        wait_out("t6_out0_pc", 64'hFFFF_FFFF_FFFF_FFFC, lat);
        wait_out("t6_out1_pc", 64'h0, lat);
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
